// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;
  // Five internal digits hold the 16-bit maximum of 65535.
  localparam int unsigned INT_DIGITS  = 5;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam int unsigned MAX_DISPLAY = 9999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: digits of 5 or more get +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Pure 4-bit add; never carries into the neighbouring digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= ADD3_THRESH) digit_o = digit_i + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter, one bit per clock.
// Optional macro BCD_AUTO_RESTART_EN: ignore start and convert continuously,
// re-capturing bin every WIDTH+1 cycles.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned SCR_W = BCD_DIGIT_W * INT_DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic [SCR_W-1:0]     scratch_q, scratch_d;
  logic [SCR_W-1:0]     scratch_adj;
  logic [WIDTH-1:0]     binreg_q, binreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 go;

`ifdef BCD_AUTO_RESTART_EN
  logic unused_start;
  assign unused_start = start;
  assign go = 1'b1;
`else
  assign go = start;
`endif

  genvar g;
  generate
    for (g = 0; g < INT_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Next-state logic for the IDLE/SHIFT/DONE sequencer and datapath.
  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    binreg_d  = binreg_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          binreg_d  = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {scratch_adj[SCR_W-2:0], binreg_q[WIDTH-1]};
        binreg_d  = binreg_q << 1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d  = scratch_q[4*DIGITS-1:0];
        ovf_d  = |scratch_q[SCR_W-1:4*DIGITS];
        done_d = 1'b1;
`ifdef BCD_AUTO_RESTART_EN
        binreg_d  = bin;
        scratch_d = '0;
        cnt_d     = CNT_W'(WIDTH);
        state_d   = SHIFT;
`else
        state_d   = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      binreg_q  <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      binreg_q  <= binreg_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (default build, or BCD_AUTO_RESTART_EN).
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_bcd;
  logic        prev_ovf;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Decimal digits of v mod 10000, packed as hex nibbles.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    int unsigned m;
    m = v % 10000;
    return 16'(((m / 1000) << 12) | (((m / 100) % 10) << 8) |
               (((m / 10) % 10) << 4) | (m % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one conversion; optionally pulse start with bin=42 at cycle inj.
  task automatic convert(input int unsigned v, input int inj);
    int lat;
    int ndone;
    logic [15:0] eb;
    logic eo;
    lat   = -1;
    ndone = 0;
    eb    = ref_bcd(v);
    eo    = (v > 9999);
    bin   = 16'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    check("bcd_hold", 32'(bcd), 32'(prev_bcd));
    check("ovf_hold", 32'(overflow), 32'(prev_ovf));
    for (int i = 1; i <= 30; i++) begin
      if (i == inj) begin
        start = 1'b1;
        bin   = 16'd42;
      end
      if (i == inj + 1) start = 1'b0;
      tick();
      if (i == 8) check("busy_mid", 32'(busy), 1);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          check("bcd", 32'(bcd), 32'(eb));
          check("overflow", 32'(overflow), 32'(eo));
          check("busy_at_done", 32'(busy), 0);
        end
      end
    end
    check("latency", 32'(lat), 17);
    check("done_count", 32'(ndone), 1);
    prev_bcd = eb;
    prev_ovf = eo;
  endtask

  // Returns the number of cycles until done is seen, or -1 after 40 cycles.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    bin      = 16'd0;
    prev_bcd = 16'd0;
    prev_ovf = 1'b0;
`ifdef BCD_AUTO_RESTART_EN
    bin = 16'd500;
    repeat (2) tick();
    check("rst_bcd", 32'(bcd), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;
    wait_done(n);
    check("auto_first_seen", 32'(n > 0), 1);
    check("auto_bcd_500a", 32'(bcd), 32'h0500);
    wait_done(n);
    check("auto_period", 32'(n), 17);
    check("auto_bcd_500b", 32'(bcd), 32'h0500);
    repeat (5) tick();
    bin = 16'd501;
    wait_done(n);
    check("auto_period2", 32'(n + 5), 17);
    check("auto_bcd_500c", 32'(bcd), 32'h0500);
    wait_done(n);
    check("auto_period3", 32'(n), 17);
    check("auto_bcd_501", 32'(bcd), 32'h0501);
    check("auto_ovf", 32'(overflow), 0);
`else
    repeat (2) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bcd", 32'(bcd), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    tick();

    convert(0, -1);
    convert(1234, -1);
    convert(9999, -1);
    convert(10000, -1);
    convert(65535, -1);
    convert(1234, 5);

    // Reset in the middle of converting 4321.
    bin   = 16'd4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_bcd", 32'(bcd), 0);
    check("abort_ovf", 32'(overflow), 0);
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) n++;
    end
    check("abort_no_done", 32'(n), 0);
    prev_bcd = 16'd0;
    prev_ovf = 1'b0;
    convert(7, -1);

    for (int k = 0; k < 12; k++) begin
      convert($urandom_range(0, 65535), -1);
    end
    convert(1, -1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
